// File: rtl/dmem_port_pkg.sv
// Shared definitions for the data-memory port: depth default, byte-lane write
// encodings, FSM states and the lane-merge helper used for forwarding.
package dmem_port_pkg;

    localparam int DEPTH_LOG2_DEF = 10;

    localparam logic [3:0] WREN_SW   = 4'b0000;
    localparam logic [3:0] WREN_SH   = 4'b1100;
    localparam logic [3:0] WREN_SB   = 4'b1110;
    localparam logic [3:0] WREN_NONE = 4'b1111;

    // Consecutive loads tolerated over a held store before it is forced out.
    localparam logic [1:0] HOLD_LIMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                                input logic [31:0] over,
                                                input logic [3:0]  mask_n);
        logic [31:0] res;
        res = base;
        for (int b = 0; b < 4; b++) begin
            if (!mask_n[b]) res[b*8 +: 8] = over[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous read, active-low byte-masked write.
// Contents are deliberately not reset.
module dmem_ram
    import dmem_port_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  i_re,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [3:0]            i_wmask_n,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!i_wmask_n[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_port.sv
// Data-memory port: one-entry posted store buffer with store-to-load forwarding
// in front of a single-port RAM; loads return a fixed one cycle after accept.
//
//   state | meaning
//   IDLE  | store buffer empty
//   HELD  | store buffer full, drains on any cycle without an accepted load
//   DRAIN | forced drain after HOLD_LIMIT loads, requests stalled
module dmem_port
    import dmem_port_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  wren,
    input  logic [31:0] wdata,
    output logic [31:0] dm_data,
    output logic        rsp_valid
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_hold_cnt;
    logic [1:0]            w_cnt_nxt;

    logic                  r_buf_valid;
    logic [DEPTH_LOG2-1:0] r_buf_addr;
    logic [31:0]           r_buf_data;
    logic [3:0]            r_buf_mask_n;

    logic                  r_rsp_valid;
    logic [31:0]           r_fwd_data;
    logic [3:0]            r_fwd_mask_n;
    logic [31:0]           r_dm_hold;

    logic [DEPTH_LOG2-1:0] w_addr;
    logic                  w_unused_addr;
    logic                  w_is_load;
    logic                  w_acc;
    logic                  w_acc_ld;
    logic                  w_acc_st;
    logic                  w_drain;
    logic                  w_buf_fill;
    logic                  w_fwd_hit;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-1:0] w_ram_addr;
    logic [31:0]           w_ram_rdata;
    logic [31:0]           w_merged;

    assign w_addr        = dm_addr[DEPTH_LOG2-1:0];
    assign w_unused_addr = ^dm_addr[31:DEPTH_LOG2];
    assign w_is_load     = (wren == WREN_NONE);
    assign req_ready     = (r_state != ST_DRAIN);
    // Requests are gated by reset so nothing lands in the buffer or RAM then.
    assign w_acc         = req_valid & req_ready & rstd;
    assign w_acc_ld      = w_acc & w_is_load;
    assign w_acc_st      = w_acc & ~w_is_load;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_hold_cnt;
        w_drain     = 1'b0;
        w_buf_fill  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc_st) begin
                    w_buf_fill  = 1'b1;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_acc_ld) begin
                    w_cnt_nxt = r_hold_cnt + 2'd1;
                    if ((r_hold_cnt + 2'd1) == HOLD_LIMIT) w_state_nxt = ST_DRAIN;
                end else begin
                    w_drain   = 1'b1;
                    w_cnt_nxt = 2'd0;
                    if (w_acc_st) w_buf_fill  = 1'b1;
                    else          w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_drain     = 1'b1;
                w_cnt_nxt   = 2'd0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_cnt_nxt;
        end
    end

    // A pending store is discarded on reset, so its RAM write is gated too.
    assign w_ram_we   = w_drain & rstd;
    assign w_ram_addr = w_drain ? r_buf_addr : w_addr;
    assign w_fwd_hit  = r_buf_valid & (r_buf_addr == w_addr);

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .i_re      (w_acc_ld),
        .i_we      (w_ram_we),
        .i_addr    (w_ram_addr),
        .i_wmask_n (r_buf_mask_n),
        .i_wdata   (r_buf_data),
        .o_rdata   (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstd) begin
            r_buf_valid  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_fwd_mask_n <= WREN_NONE;
            r_dm_hold    <= 32'h0;
        end else begin
            if (w_buf_fill)   r_buf_valid <= 1'b1;
            else if (w_drain) r_buf_valid <= 1'b0;
            r_rsp_valid <= w_acc_ld;
            if (w_acc_ld)    r_fwd_mask_n <= w_fwd_hit ? r_buf_mask_n : WREN_NONE;
            if (r_rsp_valid) r_dm_hold    <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_fill) begin
            r_buf_addr   <= w_addr;
            r_buf_data   <= wdata;
            r_buf_mask_n <= wren;
        end
        if (w_acc_ld) r_fwd_data <= r_buf_data;
    end

    assign w_merged  = merge_lanes(w_ram_rdata, r_fwd_data, r_fwd_mask_n);
    assign dm_data   = r_rsp_valid ? w_merged : r_dm_hold;
    assign rsp_valid = r_rsp_valid;

endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 Parameter: DEPTH_LOG2, default 10, log2 of RAM depth in 32-bit words.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstd  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  execute stage presents a memory request this cycle.
REQ-005 req_ready  output  1  port accepts a request this cycle; accept = req_valid & req_ready.
REQ-006 dm_addr  input  32  word address; only dm_addr[DEPTH_LOG2-1:0] used, upper bits ignored (aliasing).
REQ-007 wren  input  4  active-low byte-lane write enables: 0000 word store, 1100 halfword store (lanes 1:0), 1110 byte store (lane 0), 1111 load.
REQ-008 wdata  input  32  store data, right-aligned in low lanes; unwritten lanes ignored.
REQ-009 dm_data  output  32  load result word (raw; sign extension done by execute stage).
REQ-010 rsp_valid  output  1  dm_data valid for the load accepted in the previous cycle.

Function
REQ-011 Any wren other than 1111 shall be treated as a store, writing exactly the lanes whose bit is 0.
REQ-012 Stores shall be posted into a one-entry store buffer (addr, data, active-low mask); no response is generated for stores.
REQ-013 Loads shall have fixed 1-cycle latency: rsp_valid high and dm_data valid in the cycle after accept, otherwise rsp_valid low and dm_data holding its last value.
REQ-014 Load data shall be the RAM word with buffered bytes substituted lane-by-lane when the buffer is valid and its address equals the load address (store-to-load forwarding).
REQ-015 RAM is single-port: at most one access (read or buffer drain) per cycle; an accepted load has priority over a drain.
REQ-016 FSM states: IDLE (buffer empty), HELD (buffer full), DRAIN (forced drain).
REQ-017 IDLE: req_ready=1; accepted store fills buffer -> HELD; load or no request -> IDLE.
REQ-018 HELD: req_ready=1; accepted load -> hold counter +1, stay HELD; any cycle without accepted load drains buffer to RAM and clears counter.
REQ-019 HELD drain cycle with accepted store: buffer refilled with new store same cycle -> HELD; without store -> IDLE.
REQ-020 HELD with hold counter reaching 2 -> DRAIN; DRAIN: req_ready=0, buffer written to RAM, counter cleared -> IDLE.
REQ-021 Store to same address as buffered entry while HELD: old entry drains first, new entry replaces it; RAM ends with both merged lane-wise, newer bytes winning.
REQ-022 req_valid while req_ready=0 shall be ignored with no state change; the requester holds the request.

Reset
REQ-023 rstd=0 at a rising edge: state IDLE, buffer invalid (pending store discarded), hold counter 0, rsp_valid 0, dm_data 32'h0.
REQ-024 RAM contents shall not be reset; a load in flight when reset asserts shall produce no response.

Structure
REQ-025 Shared package holds: DEPTH_LOG2 default, wren encodings (WREN_SW 0000, WREN_SH 1100, WREN_SB 1110, WREN_NONE 1111), FSM state enum.
REQ-026 One sub-module dmem_ram: single-port, synchronous read, active-low byte-masked write, DEPTH 2**DEPTH_LOG2; FSM, buffer and forwarding mux stay in dmem_port.

Verification
REQ-027 Store 0x12345678 wren 0000 addr 5, idle, load addr 5 -> next cycle rsp_valid=1, dm_data=0x12345678.
REQ-028 RAM[7]=0xAABBCCDD; store 0x000000EE wren 1110 addr 7, immediate load addr 7 -> dm_data=0xAABBCCEE via forwarding.
REQ-029 Store addr 3 then three back-to-back loads -> req_ready low in cycle after second load, buffer drained, third load accepted one cycle later with correct data.
REQ-030 Store 0x1111 wren 1100 addr 9 then store 0x22 wren 1110 addr 9 back-to-back over RAM[9]=0 -> later load returns 0x00001122.
REQ-031 Store pending in buffer, rstd low one cycle, load same addr -> old RAM value returned, rsp_valid 0 during reset.
REQ-032 Load addr 0x0000_0405 with DEPTH_LOG2=10 -> returns RAM[5].
